sync_fifo_pkt: RTL and testbench

Single-clock, parametrised FIFO for AXI-stream-style traffic with first-word-fall-through output. It generalises the existing power-of-two FIFO in several ways: any depth, a live occupancy count, runtime-programmable thresholds, and an optional packet (store-and-forward) mode keyed on a last flag. It sits between stream producers and consumers that share one clock, such as the DMA-to-accelerator boundary.

---
 rtl/sync_fifo_pkt.sv | 173 +++++++++++++++++
 tb/tb_sync_fifo_pkt.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_pkt.sv
// rtl/sync_fifo_pkt.sv - single-clock FWFT stream FIFO with occupancy count, thresholds and optional packet mode
module sync_fifo_pkt #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int PACKET_MODE = 0,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic [CNT_W-1:0]  prog_full_thresh,
    input  logic [CNT_W-1:0]  prog_empty_thresh,
    output logic [CNT_W-1:0]  count,
    output logic              prog_full,
    output logic              prog_empty,
    output logic              oversize
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [DATA_W:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              s_ready_q, s_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              prog_full_q, prog_full_d;
    logic              prog_empty_q, prog_empty_d;

    logic              pkt_gate;
    logic              wr_en;
    logic              rd_en;
    logic              load;
    logic [CNT_W-1:0]  mem_cnt;

    assign wr_en   = s_valid & s_ready_q;
    assign m_valid = out_valid_q & pkt_gate;
    assign rd_en   = m_valid & m_ready;
    // count includes the output register, so the array holds one fewer when it is full
    assign mem_cnt = count_q - CNT_W'(out_valid_q);
    assign load    = (mem_cnt != '0) & (~out_valid_q | rd_en);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        count_d      = count_q;

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end

        if (load) begin
            rd_ptr_d                 = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            {out_last_d, out_data_d} = mem[rd_ptr_q];
            out_valid_d              = 1'b1;
        end else if (rd_en) begin
            out_valid_d = 1'b0;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        s_ready_d    = count_d < DEPTH_C;
        prog_full_d  = count_d >= prog_full_thresh;
        prog_empty_d = count_d <= prog_empty_thresh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            s_ready_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            s_ready_q    <= s_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            prog_full_q  <= prog_full_d;
            prog_empty_q <= prog_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {s_last, s_data};
        end
    end

    generate
        if (PACKET_MODE != 0) begin : g_pkt
            logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
            logic             rel_q, rel_d;
            logic             oversize_q, oversize_d;
            logic             pkt_in;
            logic             pkt_out;

            assign pkt_in  = wr_en & s_last;
            assign pkt_out = rd_en & out_last_q;

            always_comb begin
                pkt_cnt_d  = pkt_cnt_q;
                rel_d      = rel_q;
                oversize_d = oversize_q;
                if (pkt_in & ~pkt_out) begin
                    pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                end else if (~pkt_in & pkt_out) begin
                    pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
                end
                // full with no complete packet would deadlock, so stream the head packet out unframed
                if ((count_q == DEPTH_C) && (pkt_cnt_q == '0)) begin
                    rel_d      = 1'b1;
                    oversize_d = 1'b1;
                end
                if (pkt_out) begin
                    rel_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pkt_cnt_q  <= '0;
                    rel_q      <= 1'b0;
                    oversize_q <= 1'b0;
                end else begin
                    pkt_cnt_q  <= pkt_cnt_d;
                    rel_q      <= rel_d;
                    oversize_q <= oversize_d;
                end
            end

            assign pkt_gate = (pkt_cnt_q != '0) | rel_q;
            assign oversize = oversize_q;
        end else begin : g_word
            assign pkt_gate = 1'b1;
            assign oversize = 1'b0;
        end
    endgenerate

    assign s_ready    = s_ready_q;
    assign m_data     = out_data_q;
    assign m_last     = out_last_q;
    assign count      = count_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// tb/tb_sync_fifo_pkt.sv - directed table-driven bench for sync_fifo_pkt in word and packet modes
module tb_sync_fifo_pkt;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // word-mode instance, DEPTH=5
    logic [31:0] w_sd, w_md;
    logic        w_sl, w_sv, w_srdy, w_ml, w_mv, w_mr, w_pf, w_pe, w_ovs;
    logic [2:0]  w_pft, w_pet, w_cnt;

    // packet-mode instance, DEPTH=8
    logic [31:0] p_sd, p_md;
    logic        p_sl, p_sv, p_srdy, p_ml, p_mv, p_mr, p_pf, p_pe, p_ovs;
    logic [3:0]  p_pft, p_pet, p_cnt;

    sync_fifo_pkt #(.DATA_W(32), .DEPTH(5), .PACKET_MODE(0)) u_word (
        .clk(clk), .rst(rst),
        .s_data(w_sd), .s_last(w_sl), .s_valid(w_sv), .s_ready(w_srdy),
        .m_data(w_md), .m_last(w_ml), .m_valid(w_mv), .m_ready(w_mr),
        .prog_full_thresh(w_pft), .prog_empty_thresh(w_pet),
        .count(w_cnt), .prog_full(w_pf), .prog_empty(w_pe), .oversize(w_ovs)
    );

    sync_fifo_pkt #(.DATA_W(32), .DEPTH(8), .PACKET_MODE(1)) u_pkt (
        .clk(clk), .rst(rst),
        .s_data(p_sd), .s_last(p_sl), .s_valid(p_sv), .s_ready(p_srdy),
        .m_data(p_md), .m_last(p_ml), .m_valid(p_mv), .m_ready(p_mr),
        .prog_full_thresh(p_pft), .prog_empty_thresh(p_pet),
        .count(p_cnt), .prog_full(p_pf), .prog_empty(p_pe), .oversize(p_ovs)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        sl;
        logic        mr;
        logic [2:0]  pft;
        logic [2:0]  pet;
        logic [2:0]  cnt;
        logic        srdy;
        logic        mv;
        logic [31:0] md;
        logic        ml;
        logic        pf;
        logic        pe;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic sv, input logic [31:0] sd, input logic sl, input logic mr,
                                input logic [2:0] pft, input logic [2:0] pet, input logic [2:0] cnt,
                                input logic srdy, input logic mv, input logic [31:0] md, input logic ml,
                                input logic pf, input logic pe);
        vec_t v;
        v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr; v.pft = pft; v.pet = pet;
        v.cnt = cnt; v.srdy = srdy; v.mv = mv; v.md = md; v.ml = ml; v.pf = pf; v.pe = pe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pstep(input logic sv, input logic [31:0] sd, input logic sl, input logic mr);
        p_sv = sv; p_sd = sd; p_sl = sl; p_mr = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " w_cnt"}, w_cnt, 0);   chk({tag, " w_srdy"}, w_srdy, 0);
        chk({tag, " w_mv"}, w_mv, 0);     chk({tag, " w_pf"}, w_pf, 0);
        chk({tag, " w_pe"}, w_pe, 1);     chk({tag, " w_md"}, w_md, 0);
        chk({tag, " w_ml"}, w_ml, 0);     chk({tag, " w_ovs"}, w_ovs, 0);
        chk({tag, " p_cnt"}, p_cnt, 0);   chk({tag, " p_srdy"}, p_srdy, 0);
        chk({tag, " p_mv"}, p_mv, 0);     chk({tag, " p_pf"}, p_pf, 0);
        chk({tag, " p_pe"}, p_pe, 1);     chk({tag, " p_md"}, p_md, 0);
        chk({tag, " p_ml"}, p_ml, 0);     chk({tag, " p_ovs"}, p_ovs, 0);
    endtask

    initial begin
        logic [32:0] sb[$];
        logic [32:0] exp_w;
        logic        wr, rd, cap_l;
        logic [31:0] cap_d;
        int          pushed, popped, cyc;

        rst = 1'b1;
        w_sv = 0; w_sd = 0; w_sl = 0; w_mr = 0; w_pft = 3'd4; w_pet = 3'd1;
        p_sv = 0; p_sd = 0; p_sl = 0; p_mr = 0; p_pft = 4'd8; p_pet = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("por");
        rst = 1'b0;

        //          sv  sd      sl mr pft pet  cnt srdy mv md      ml pf pe
        vecs.push_back(mk(0, 32'h0,  0, 0, 4, 1,  0, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hA1, 0, 0, 4, 1,  1, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hA2, 0, 0, 4, 1,  2, 1, 1, 32'hA1, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA3, 0, 0, 4, 1,  3, 1, 1, 32'hA1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 0, 4, 1,  3, 1, 1, 32'hA1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  2, 1, 1, 32'hA2, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  1, 1, 1, 32'hA3, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  0, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 4, 1,  0, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hB1, 0, 0, 4, 1,  1, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hB2, 0, 0, 4, 1,  2, 1, 1, 32'hB1, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB3, 0, 0, 4, 1,  3, 1, 1, 32'hB1, 0, 0, 0));
        vecs.push_back(mk(1, 32'hB4, 1, 0, 4, 1,  4, 1, 1, 32'hB1, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  3, 1, 1, 32'hB2, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  2, 1, 1, 32'hB3, 0, 0, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 4, 1,  1, 1, 1, 32'hB4, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 2, 1,  1, 1, 1, 32'hB4, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 2, 1,  1, 1, 1, 32'hB4, 1, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 1, 1,  1, 1, 1, 32'hB4, 1, 1, 1));
        vecs.push_back(mk(0, 32'h0,  0, 0, 0, 0,  1, 1, 1, 32'hB4, 1, 1, 0));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  0, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hC1, 0, 0, 5, 5,  1, 1, 0, 32'h0,  0, 0, 1));
        vecs.push_back(mk(1, 32'hC2, 0, 0, 5, 5,  2, 1, 1, 32'hC1, 0, 0, 1));
        vecs.push_back(mk(1, 32'hC3, 0, 0, 5, 5,  3, 1, 1, 32'hC1, 0, 0, 1));
        vecs.push_back(mk(1, 32'hC4, 0, 0, 5, 5,  4, 1, 1, 32'hC1, 0, 0, 1));
        vecs.push_back(mk(1, 32'hC5, 0, 0, 5, 5,  5, 0, 1, 32'hC1, 0, 1, 1));
        vecs.push_back(mk(1, 32'hC6, 0, 0, 5, 5,  5, 0, 1, 32'hC1, 0, 1, 1));
        vecs.push_back(mk(1, 32'hC6, 0, 1, 5, 5,  4, 1, 1, 32'hC2, 0, 0, 1));
        vecs.push_back(mk(1, 32'hC6, 0, 0, 5, 5,  5, 0, 1, 32'hC2, 0, 1, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  4, 1, 1, 32'hC3, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  3, 1, 1, 32'hC4, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  2, 1, 1, 32'hC5, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  1, 1, 1, 32'hC6, 0, 0, 1));
        vecs.push_back(mk(0, 32'h0,  0, 1, 5, 5,  0, 1, 0, 32'h0,  0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            w_sv = vecs[i].sv; w_sd = vecs[i].sd; w_sl = vecs[i].sl; w_mr = vecs[i].mr;
            w_pft = vecs[i].pft; w_pet = vecs[i].pet;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), w_cnt, vecs[i].cnt);
            chk($sformatf("v%0d s_ready", i), w_srdy, vecs[i].srdy);
            chk($sformatf("v%0d m_valid", i), w_mv, vecs[i].mv);
            chk($sformatf("v%0d prog_full", i), w_pf, vecs[i].pf);
            chk($sformatf("v%0d prog_empty", i), w_pe, vecs[i].pe);
            if (vecs[i].mv) begin
                chk($sformatf("v%0d m_data", i), w_md, vecs[i].md);
                chk($sformatf("v%0d m_last", i), w_ml, vecs[i].ml);
            end
        end

        // 20 words streamed through DEPTH=5 with random read stalls
        pushed = 0; popped = 0; cyc = 0;
        while (popped < 20 && cyc < 200) begin
            w_sv  = (pushed < 20);
            w_sd  = 32'h100 + 32'(pushed);
            w_sl  = (pushed % 4 == 3);
            w_mr  = ($urandom_range(0, 3) != 0);
            wr    = w_sv & w_srdy;
            rd    = w_mv & w_mr;
            cap_d = w_md;
            cap_l = w_ml;
            @(posedge clk);
            #1;
            cyc++;
            if (rd) begin
                chk("stream underflow", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_w = sb.pop_front();
                    chk($sformatf("stream word %0d data", popped), cap_d, exp_w[31:0]);
                    chk($sformatf("stream word %0d last", popped), cap_l, exp_w[32]);
                end
                popped++;
            end
            if (wr) begin
                sb.push_back({w_sl, w_sd});
                pushed++;
            end
        end
        chk("stream words read", popped, 20);
        w_sv = 0; w_sd = 0; w_sl = 0; w_mr = 0;

        // packet mode: incomplete packet is held back
        pstep(1, 32'hD1, 0, 0);
        pstep(1, 32'hD2, 0, 0);
        pstep(1, 32'hD3, 0, 0);
        chk("pkt partial m_valid", p_mv, 0);
        pstep(0, 32'h0, 0, 0);
        chk("pkt partial hold m_valid", p_mv, 0);
        chk("pkt partial count", p_cnt, 3);
        pstep(1, 32'hD4, 1, 0);
        chk("pkt complete m_valid", p_mv, 1);
        chk("pkt head data", p_md, 32'hD1);
        pstep(0, 32'h0, 0, 1);
        chk("pkt rd2 data", p_md, 32'hD2);
        pstep(0, 32'h0, 0, 1);
        chk("pkt rd3 data", p_md, 32'hD3);
        pstep(0, 32'h0, 0, 1);
        chk("pkt rd4 data", p_md, 32'hD4);
        chk("pkt rd4 last", p_ml, 1);
        pstep(0, 32'h0, 0, 1);
        chk("pkt drained m_valid", p_mv, 0);
        chk("pkt drained count", p_cnt, 0);
        pstep(1, 32'hE0, 0, 0);
        pstep(0, 32'h0, 0, 0);
        pstep(0, 32'h0, 0, 0);
        chk("pkt_cnt zero m_valid", p_mv, 0);
        chk("pkt oversize idle", p_ovs, 0);

        // fill both instances, then reset asynchronously mid-packet
        for (int i = 1; i <= 5; i++) begin
            w_sv = (i <= 3); w_sd = 32'hF0 + 32'(i);
            pstep(1, 32'hE0 + 32'(i), 0, 0);
        end
        w_sv = 0;
        pstep(0, 32'h0, 0, 0);
        chk("pre-reset p_count", p_cnt, 6);
        chk("pre-reset w_count", w_cnt, 3);
        chk("pre-reset w_m_valid", w_mv, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pstep(0, 32'h0, 0, 0);
        chk("post-reset w_count", w_cnt, 0);
        chk("post-reset w_s_ready", w_srdy, 1);
        chk("post-reset p_s_ready", p_srdy, 1);
        pstep(0, 32'h0, 0, 0);
        chk("post-reset w_m_valid", w_mv, 0);
        chk("post-reset p_m_valid", p_mv, 0);
        chk("post-reset p_count", p_cnt, 0);
        pstep(1, 32'h5A, 1, 0);
        pstep(0, 32'h0, 0, 0);
        chk("fresh pkt m_valid", p_mv, 1);
        chk("fresh pkt data", p_md, 32'h5A);
        chk("fresh pkt last", p_ml, 1);
        pstep(0, 32'h0, 0, 1);
        chk("fresh pkt drained", p_mv, 0);

        // oversize release on DEPTH=8 with no s_last
        for (int i = 0; i < 8; i++) pstep(1, 32'h200 + 32'(i), 0, 0);
        chk("ovs full count", p_cnt, 8);
        chk("ovs full s_ready", p_srdy, 0);
        chk("ovs before flag", p_ovs, 0);
        chk("ovs before m_valid", p_mv, 0);
        pstep(0, 32'h0, 0, 0);
        chk("ovs flag", p_ovs, 1);
        chk("ovs m_valid", p_mv, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovs drain %0d valid", i), p_mv, 1);
            chk($sformatf("ovs drain %0d data", i), p_md, 32'h200 + 32'(i));
            chk($sformatf("ovs drain %0d last", i), p_ml, 0);
            pstep(0, 32'h0, 0, 1);
        end
        chk("ovs drained count", p_cnt, 0);
        chk("ovs drained m_valid", p_mv, 0);
        pstep(1, 32'h209, 1, 0);
        pstep(0, 32'h0, 0, 0);
        chk("ovs tail valid", p_mv, 1);
        chk("ovs tail data", p_md, 32'h209);
        chk("ovs tail last", p_ml, 1);
        pstep(0, 32'h0, 0, 1);
        chk("ovs tail read m_valid", p_mv, 0);
        chk("ovs sticky", p_ovs, 1);
        pstep(1, 32'h300, 0, 0);
        pstep(0, 32'h0, 0, 0);
        pstep(0, 32'h0, 0, 0);
        chk("release cleared m_valid", p_mv, 0);
        chk("release cleared count", p_cnt, 1);
        chk("ovs still sticky", p_ovs, 1);
        chk("word oversize tied", w_ovs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
